// File: rtl/hv_segment_bundler.sv
// hv_segment_bundler: accumulates per-bit popcounts of level-HV segments over
// all features of one sample, then thresholds them into a query-HV segment.
// Beats carry FEATURES_PER_CC level HVs; padding features in the last chunk
// are masked out so that the counters can never exceed NUM_FEATURES.
module hv_segment_bundler #(
   parameter int  HV_DIM          = 64,
   parameter int  FEATURES_PER_CC = 59,
   parameter int  NUM_FEATURES    = 617,
   localparam int CNT_W           = $clog2(NUM_FEATURES + 1)
) (
   input  logic                                   clk,
   input  logic                                   nrst,
   input  logic [FEATURES_PER_CC-1:0][HV_DIM-1:0] level_hvs,
   input  logic                                   level_valid,
   output logic                                   in_ready,
   input  logic                                   frame_abort,
   input  logic [CNT_W-1:0]                       threshold,
   output logic [HV_DIM-1:0]                      query_hv,
   output logic                                   query_valid,
   input  logic                                   query_ready,
   output logic                                   err_drop
);

   localparam int NUM_CHUNKS = (NUM_FEATURES + FEATURES_PER_CC - 1) / FEATURES_PER_CC;
   localparam int LAST_VALID = NUM_FEATURES - (NUM_CHUNKS - 1) * FEATURES_PER_CC;
   localparam int CHUNK_W    = $clog2(NUM_CHUNKS + 1);
   localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, THRESH, OUT} state_t;

   state_t                       state;
   state_t                       state_nxt;
   logic [CHUNK_W-1:0]           chunk_cnt;
   logic [HV_DIM-1:0][CNT_W-1:0] cnt;
   logic [HV_DIM-1:0][CNT_W-1:0] colsum;
   logic                         last_chunk;
   logic                         accept;

   // Number of counted features with bit b set; padding features of the
   // final chunk are excluded.
   function automatic logic [CNT_W-1:0] column_sum(
      input logic [FEATURES_PER_CC-1:0][HV_DIM-1:0] hvs,
      input int                                     b,
      input logic                                   last
   );
      logic [CNT_W-1:0] s;
      s = '0;
      for (int f = 0; f < FEATURES_PER_CC; f++) begin
         if (!last || f < LAST_VALID)
            s = s + CNT_W'(hvs[f][b]);
      end
      return s;
   endfunction

   // One query bit: set when the bit's count reaches the threshold.
   function automatic logic meets_threshold(
      input logic [CNT_W-1:0] count,
      input logic [CNT_W-1:0] thr
   );
      return (count >= thr);
   endfunction

   // Input is held off while reset is asserted and while a result is pending.
   assign in_ready   = !nrst && (state == IDLE || state == ACCUM);
   assign accept     = level_valid && in_ready && !frame_abort;
   assign last_chunk = (chunk_cnt == LAST_CHUNK);

   // Column sums of the current beat, one per HV bit.
   always_comb begin
      colsum = '0;
      for (int b = 0; b < HV_DIM; b++)
         colsum[b] = column_sum(level_hvs, b, last_chunk);
   end

   // State register.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_nxt = state;
      if (frame_abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = (NUM_CHUNKS == 1) ? THRESH : ACCUM;
            ACCUM:   if (accept && last_chunk) state_nxt = THRESH;
            THRESH:  state_nxt = OUT;
            OUT:     if (query_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Counters, chunk index, query register and the sticky drop flag.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         cnt         <= '0;
         chunk_cnt   <= '0;
         query_hv    <= '0;
         query_valid <= 1'b0;
         err_drop    <= 1'b0;
      end else begin
         if (level_valid && !in_ready && !frame_abort)
            err_drop <= 1'b1;
         if (frame_abort) begin
            cnt         <= '0;
            chunk_cnt   <= '0;
            query_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     cnt       <= colsum;
                     chunk_cnt <= CHUNK_W'(1);
                  end
               end
               ACCUM: begin
                  if (accept) begin
                     for (int b = 0; b < HV_DIM; b++)
                        cnt[b] <= cnt[b] + colsum[b];
                     chunk_cnt <= chunk_cnt + CHUNK_W'(1);
                  end
               end
               THRESH: begin
                  for (int b = 0; b < HV_DIM; b++)
                     query_hv[b] <= meets_threshold(cnt[b], threshold);
                  query_valid <= 1'b1;
               end
               OUT: begin
                  if (query_ready) begin
                     query_valid <= 1'b0;
                     cnt         <= '0;
                     chunk_cnt   <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hv_segment_bundler.sv
// Testbench for hv_segment_bundler: a small configuration with a fixed vector
// and the default configuration driven with random and directed samples,
// compared against a per-feature popcount/threshold reference model.
module tb_hv_segment_bundler;

   localparam int HV  = 64;
   localparam int FPC = 59;
   localparam int NF  = 617;
   localparam int NCH = 11;
   localparam int CW  = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [FPC-1:0][HV-1:0] lv_hvs;
   logic                   lv_valid, in_ready, abort, qv, qready, err;
   logic [CW-1:0]          thr;
   logic [HV-1:0]          qhv;

   logic [1:0][7:0] s_hvs;
   logic            s_valid, s_in_ready, s_abort, s_qv, s_qready, s_err;
   logic [2:0]      s_thr;
   logic [7:0]      s_qhv;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   logic [FPC-1:0][HV-1:0] beats [NCH];
   logic [HV-1:0]          exp_q;
   int                     t;

   hv_segment_bundler dut (
      .clk(clk), .nrst(rst), .level_hvs(lv_hvs), .level_valid(lv_valid),
      .in_ready(in_ready), .frame_abort(abort), .threshold(thr),
      .query_hv(qhv), .query_valid(qv), .query_ready(qready), .err_drop(err)
   );

   hv_segment_bundler #(.HV_DIM(8), .FEATURES_PER_CC(2), .NUM_FEATURES(5)) sdut (
      .clk(clk), .nrst(rst), .level_hvs(s_hvs), .level_valid(s_valid),
      .in_ready(s_in_ready), .frame_abort(s_abort), .threshold(s_thr),
      .query_hv(s_qhv), .query_valid(s_qv), .query_ready(s_qready), .err_drop(s_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total_cnt++;
      assert (obs === expv) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: walk the features of the sample in global order, count each
   // bit over the first NF features only, compare with the threshold.
   function automatic logic [63:0] model(input int th);
      logic [63:0] r;
      int n;
      r = '0;
      for (int b = 0; b < HV; b++) begin
         n = 0;
         for (int g = 0; g < NF; g++)
            n += int'(beats[g / FPC][g % FPC][b]);
         r[b] = (n >= th);
      end
      return r;
   endfunction

   task automatic fill_random();
      for (int c = 0; c < NCH; c++)
         for (int f = 0; f < FPC; f++)
            beats[c][f] = {$urandom, $urandom};
   endtask

   task automatic send_beat(input int c);
      lv_hvs   = beats[c];
      lv_valid = 1'b1;
      tick();
      lv_valid = 1'b0;
      for (int f = 0; f < FPC; f++)
         lv_hvs[f] = {$urandom, $urandom};
   endtask

   task automatic send_sample(input int max_gap);
      for (int c = 0; c < NCH; c++) begin
         repeat ($urandom_range(0, max_gap)) tick();
         send_beat(c);
      end
   endtask

   task automatic check_result(input string tag, input int th);
      check({tag, "_qv_early"}, 64'(qv), 64'd0);
      check({tag, "_inrdy_thresh"}, 64'(in_ready), 64'd0);
      tick();
      check({tag, "_qv"}, 64'(qv), 64'd1);
      check({tag, "_qhv"}, qhv, model(th));
   endtask

   task automatic handshake(input string tag);
      qready = 1'b1;
      tick();
      qready = 1'b0;
      check({tag, "_qv_drop"}, 64'(qv), 64'd0);
      check({tag, "_inrdy_after"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; lv_hvs = '0; lv_valid = 1'b0; abort = 1'b0; thr = '0; qready = 1'b0;
      s_hvs = '0; s_valid = 1'b0; s_abort = 1'b0; s_thr = '0; s_qready = 1'b0;
      tick(); tick();
      check("rst_qv", 64'(qv), 64'd0);
      check("rst_qhv", qhv, 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_inrdy", 64'(in_ready), 64'd0);
      check("rst_s_qv", 64'(s_qv), 64'd0);
      rst = 1'b0;
      #1;
      check("rel_inrdy", 64'(in_ready), 64'd1);
      tick();

      // Small configuration: counts 4,3,2,2,1,1,1,2 against threshold 2.
      s_thr = 3'd2;
      s_hvs[0] = 8'h0F; s_hvs[1] = 8'h03; s_valid = 1'b1; tick();
      s_hvs[0] = 8'h01; s_hvs[1] = 8'h80; tick();
      s_hvs[0] = 8'hFF; s_hvs[1] = 8'hFF; tick();
      s_valid = 1'b0;
      check("small_qv_early", 64'(s_qv), 64'd0);
      tick();
      check("small_qv", 64'(s_qv), 64'd1);
      check("small_qhv", 64'(s_qhv), 64'h8F);
      s_qready = 1'b1; tick(); s_qready = 1'b0;
      check("small_qv_drop", 64'(s_qv), 64'd0);

      // All ones at the exact-count threshold and one above.
      for (int c = 0; c < NCH; c++) beats[c] = '1;
      thr = 10'd617;
      send_sample(0);
      check_result("ones617", 617);
      handshake("ones617");
      thr = 10'd618;
      send_sample(0);
      check_result("ones618", 618);
      handshake("ones618");

      // Threshold zero.
      fill_random();
      thr = 10'd0;
      send_sample(0);
      check_result("thr0", 0);
      handshake("thr0");

      // Backpressure: result held while query_ready stays low.
      fill_random();
      thr = 10'd310;
      exp_q = model(310);
      send_sample(0);
      check_result("bp", 310);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_qhv", qhv, exp_q);
         check("bp_hold_qv", 64'(qv), 64'd1);
         check("bp_hold_inrdy", 64'(in_ready), 64'd0);
      end
      handshake("bp");
      fill_random();
      send_sample(0);
      check_result("bp_fresh", 310);
      handshake("bp_fresh");

      // Abort after 4 beats with a beat in the abort cycle, then one-hot sample.
      fill_random();
      for (int c = 0; c < 4; c++) send_beat(c);
      abort = 1'b1; lv_valid = 1'b1;
      tick();
      abort = 1'b0; lv_valid = 1'b0;
      check("abort_err", 64'(err), 64'd0);
      check("abort_qv", 64'(qv), 64'd0);
      check("abort_inrdy", 64'(in_ready), 64'd1);
      for (int c = 0; c < NCH; c++)
         for (int f = 0; f < FPC; f++)
            beats[c][f] = 64'(1) << ((c * FPC + f) % HV);
      thr = 10'd10;
      send_sample(0);
      check_result("onehot", 10);
      handshake("onehot");

      // Abort while the result is pending drops it.
      fill_random();
      thr = 10'd300;
      send_sample(1);
      check_result("abort_out", 300);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_out_qv", 64'(qv), 64'd0);
      check("abort_out_inrdy", 64'(in_ready), 64'd1);

      // Beats offered in THRESH/OUT are dropped and flagged.
      check("viol_err_before", 64'(err), 64'd0);
      fill_random();
      thr = 10'd305;
      exp_q = model(305);
      send_sample(0);
      lv_valid = 1'b1;
      for (int f = 0; f < FPC; f++) lv_hvs[f] = '1;
      tick(); tick(); tick();
      lv_valid = 1'b0;
      check("viol_err", 64'(err), 64'd1);
      check("viol_qv", 64'(qv), 64'd1);
      check("viol_qhv", qhv, exp_q);
      handshake("viol");

      // Gapped random samples against the model.
      for (int k = 0; k < 3; k++) begin
         fill_random();
         t = int'($urandom_range(290, 330));
         thr = CW'(t);
         send_sample(3);
         check_result("gap", t);
         handshake("gap");
      end
      check("err_sticky", 64'(err), 64'd1);

      // Asynchronous reset in the middle of accumulation.
      fill_random();
      for (int c = 0; c < 5; c++) send_beat(c);
      #3;
      rst = 1'b1;
      #1;
      check("arst_qv", 64'(qv), 64'd0);
      check("arst_qhv", qhv, 64'd0);
      check("arst_err", 64'(err), 64'd0);
      check("arst_inrdy", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("arst_rel_inrdy", 64'(in_ready), 64'd1);
      tick();
      fill_random();
      thr = 10'd308;
      send_sample(2);
      check_result("post_rst", 308);
      handshake("post_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
